// File: rtl/shift_deserializer_pkg.sv
// Shared constants for the shift deserializer: ALU shift opcodes, FSM state
// encodings and packing direction.
package shift_deserializer_pkg;

    localparam int unsigned SD_WIDTH = 8;

    // ALU opcodes, kept identical to the CPU opcode table
    localparam logic [3:0] SHLOP = 4'h8;
    localparam logic [3:0] SHROP = 4'h9;
    localparam logic [3:0] PUROP = 4'hC;
    localparam logic [3:0] UNCOP = 4'hF;

    localparam logic [1:0] SD_IDLE    = 2'd0;
    localparam logic [1:0] SD_COLLECT = 2'd1;
    localparam logic [1:0] SD_HOLD    = 2'd2;

    localparam logic SD_DIR_SHL = 1'b0;
    localparam logic SD_DIR_SHR = 1'b1;

endpackage

// File: rtl/shift_deserializer_align.sv
// Combinational barrel aligner: moves a k-bit partial word so that its first
// bit sits at the MSB (SHL) or LSB (SHR), zero-padding the remainder.
module shift_deserializer_align
    import shift_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = SD_WIDTH
) (
    input  logic [WIDTH-1:0]         acc,
    input  logic [$clog2(WIDTH):0]   count,
    input  logic                     dir,
    output logic [WIDTH-1:0]         aligned_c
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [CW-1:0] pad_bits;

    always_comb begin
        pad_bits = CW'(WIDTH) - count;
        if (dir == SD_DIR_SHL) begin
            aligned_c = acc << pad_bits;
        end else begin
            aligned_c = acc >> pad_bits;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Collects the ALU shift-overflow bit stream into WIDTH-bit words, packing
// MSB-first for left shifts and LSB-first for right shifts.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = SD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               alu_op,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    output logic                     bit_ready,
    input  logic                     flush,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [WIDTH-1:0]         byte_out,
    output logic [$clog2(WIDTH):0]   byte_bits,
    output logic                     op_error
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stream_q, stream_d;
    logic [WIDTH-1:0] byte_out_q, byte_out_d;
    logic [CW-1:0]    byte_bits_q, byte_bits_d;
    logic             byte_valid_q, byte_valid_d;
    logic             bit_ready_q, bit_ready_d;
    logic             op_error_q, op_error_d;

    logic             accept;
    logic             legal_op;
    logic             start_dir;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] aligned;

    // Accumulator and count as they stand after this cycle's bit, if any
    always_comb begin
        accept    = bit_valid & bit_ready_q;
        legal_op  = (alu_op == SHLOP) || (alu_op == SHROP);
        start_dir = (alu_op == SHROP) ? SD_DIR_SHR : SD_DIR_SHL;
        if (dir_q == SD_DIR_SHL) begin
            acc_shift = {acc_q[WIDTH-2:0], bit_in};
        end else begin
            acc_shift = {bit_in, acc_q[WIDTH-1:1]};
        end
        acc_nxt   = accept ? acc_shift : acc_q;
        count_nxt = accept ? CW'(count_q + CW'(1)) : count_q;
    end

    shift_deserializer_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .acc       (acc_nxt),
        .count     (count_nxt),
        .dir       (dir_q),
        .aligned_c (aligned)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        acc_d       = acc_q;
        count_d     = count_q;
        stream_d    = stream_q;
        byte_out_d  = byte_out_q;
        byte_bits_d = byte_bits_q;
        op_error_d  = 1'b0;

        case (state_q)
            SD_IDLE: begin
                if (start) begin
                    if (legal_op) begin
                        dir_d   = start_dir;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = SD_COLLECT;
                    end else begin
                        op_error_d = 1'b1;
                    end
                end
            end
            SD_COLLECT: begin
                // A restart takes priority over both flush and a data bit
                if (start) begin
                    if (legal_op) begin
                        dir_d   = start_dir;
                        acc_d   = '0;
                        count_d = '0;
                    end else begin
                        op_error_d = 1'b1;
                        state_d    = SD_IDLE;
                    end
                end else if (flush) begin
                    acc_d   = acc_nxt;
                    count_d = count_nxt;
                    if (count_nxt == '0) begin
                        state_d = SD_IDLE;
                    end else begin
                        byte_out_d  = aligned;
                        byte_bits_d = count_nxt;
                        stream_d    = 1'b0;
                        state_d     = SD_HOLD;
                    end
                end else if (accept) begin
                    acc_d   = acc_nxt;
                    count_d = count_nxt;
                    if (count_nxt == CW'(WIDTH)) begin
                        byte_out_d  = acc_nxt;
                        byte_bits_d = CW'(WIDTH);
                        stream_d    = 1'b1;
                        state_d     = SD_HOLD;
                    end
                end
            end
            SD_HOLD: begin
                if (byte_valid_q && byte_ready) begin
                    if (stream_q) begin
                        acc_d   = '0;
                        count_d = '0;
                        state_d = SD_COLLECT;
                    end else begin
                        state_d = SD_IDLE;
                    end
                end
            end
            default: begin
                state_d = SD_IDLE;
            end
        endcase

        byte_valid_d = (state_d == SD_HOLD);
        bit_ready_d  = (state_d == SD_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SD_IDLE;
            dir_q        <= SD_DIR_SHL;
            acc_q        <= '0;
            count_q      <= '0;
            stream_q     <= 1'b0;
            byte_out_q   <= '0;
            byte_bits_q  <= '0;
            byte_valid_q <= 1'b0;
            bit_ready_q  <= 1'b0;
            op_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            stream_q     <= stream_d;
            byte_out_q   <= byte_out_d;
            byte_bits_q  <= byte_bits_d;
            byte_valid_q <= byte_valid_d;
            bit_ready_q  <= bit_ready_d;
            op_error_q   <= op_error_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_bits  = byte_bits_q;
    assign op_error   = op_error_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer.
module tb_shift_deserializer;
    import shift_deserializer_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_op;
    logic         bit_valid;
    logic         bit_in;
    logic         bit_ready;
    logic         flush;
    logic         byte_valid;
    logic         byte_ready;
    logic [W-1:0] byte_out;
    logic [3:0]   byte_bits;
    logic         op_error;

    int checks   = 0;
    int failures = 0;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .alu_op     (alu_op),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .flush      (flush),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_out   (byte_out),
        .byte_bits  (byte_bits),
        .op_error   (op_error)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] op);
        start  = 1'b1;
        alu_op = op;
        tick();
        start  = 1'b0;
    endtask

    // Sends n bits, first bit taken from seq[7]
    task automatic send_bits(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = seq[7-i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; alu_op = 4'h0; bit_valid = 1'b0; bit_in = 1'b0;
        flush = 1'b0; byte_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({byte_valid, bit_ready, op_error, byte_bits, byte_out} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {byte_valid, bit_ready, op_error, byte_bits, byte_out});
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_shl_stream();
        do_start(SHLOP);
        checks++;
        if (bit_ready !== 1'b1) begin
            failures++; $display("FAIL shl_bit_ready: got %b expected 1", bit_ready);
        end
        send_bits(8'b1011_0010, 7);
        checks++;
        if (byte_valid !== 1'b0) begin
            failures++; $display("FAIL shl_early_valid: got %b expected 0", byte_valid);
        end
        send_bits(8'b0000_0000, 1);
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hB2 || byte_bits !== 4'd8 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL shl_byte: got v=%b out=%h bits=%0d rdy=%b expected v=1 out=b2 bits=8 rdy=0",
                     byte_valid, byte_out, byte_bits, bit_ready);
        end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        checks++;
        if (byte_valid !== 1'b0 || bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL shl_restream: got v=%b rdy=%b expected v=0 rdy=1", byte_valid, bit_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (bit_ready !== 1'b0 || byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush: got rdy=%b v=%b expected rdy=0 v=0", bit_ready, byte_valid);
        end
    endtask

    task automatic test_shr_stream();
        do_start(SHROP);
        send_bits(8'b1011_0010, 8);
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h4D || byte_bits !== 4'd8) begin
            failures++;
            $display("FAIL shr_byte: got v=%b out=%h bits=%0d expected v=1 out=4d bits=8",
                     byte_valid, byte_out, byte_bits);
        end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_flush(input logic [3:0] op, input logic [7:0] exp);
        do_start(op);
        send_bits(8'b1100_0000, 2);
        // third bit arrives together with flush
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        flush     = 1'b1;
        tick();
        bit_valid = 1'b0;
        flush     = 1'b0;
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== exp || byte_bits !== 4'd3) begin
            failures++;
            $display("FAIL flush_partial op=%h: got v=%b out=%h bits=%0d expected v=1 out=%h bits=3",
                     op, byte_valid, byte_out, byte_bits, exp);
        end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        tick();
        checks++;
        if (byte_valid !== 1'b0 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_to_idle op=%h: got v=%b rdy=%b expected v=0 rdy=0",
                     op, byte_valid, bit_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_start(SHLOP);
        send_bits(8'b1011_0010, 8);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            start     = 1'b1;
            alu_op    = SHROP;
            flush     = 1'b1;
            tick();
            checks++;
            if (bit_ready !== 1'b0 || byte_valid !== 1'b1 || byte_out !== 8'hB2 || byte_bits !== 4'd8) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d: got rdy=%b v=%b out=%h bits=%0d expected rdy=0 v=1 out=b2 bits=8",
                         i, bit_ready, byte_valid, byte_out, byte_bits);
            end
        end
        bit_valid = 1'b0; start = 1'b0; flush = 1'b0;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        send_bits(8'h5A, 8);
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h5A || byte_bits !== 4'd8) begin
            failures++;
            $display("FAIL stream_second: got v=%b out=%h bits=%0d expected v=1 out=5a bits=8",
                     byte_valid, byte_out, byte_bits);
        end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_illegal_op();
        do_start(PUROP);
        checks++;
        if (op_error !== 1'b1 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL illegal_idle: got err=%b rdy=%b expected err=1 rdy=0", op_error, bit_ready);
        end
        tick();
        checks++;
        if (op_error !== 1'b0 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL illegal_idle_pulse: got err=%b rdy=%b expected err=0 rdy=0", op_error, bit_ready);
        end
        do_start(SHLOP);
        send_bits(8'b1010_0000, 3);
        do_start(UNCOP);
        checks++;
        if (op_error !== 1'b1 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL illegal_collect: got err=%b rdy=%b expected err=1 rdy=0", op_error, bit_ready);
        end
        tick();
        checks++;
        if (op_error !== 1'b0 || byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_collect_pulse: got err=%b v=%b expected err=0 v=0", op_error, byte_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        do_start(SHLOP);
        send_bits(8'b1111_0000, 4);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_valid, bit_ready, op_error, byte_bits, byte_out} !== 15'h0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 0",
                     {byte_valid, bit_ready, op_error, byte_bits, byte_out});
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_start(SHLOP);
        send_bits(8'h3C, 8);
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h3C || byte_bits !== 4'd8) begin
            failures++;
            $display("FAIL post_reset_byte: got v=%b out=%h bits=%0d expected v=1 out=3c bits=8",
                     byte_valid, byte_out, byte_bits);
        end
    endtask

    initial begin
        test_reset();
        test_shl_stream();
        test_shr_stream();
        test_flush(SHLOP, 8'hC0);
        test_flush(SHROP, 8'h03);
        test_back_to_back();
        test_illegal_op();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Bit-serial collector that sits beside the CPU ALU and assembles the single-bit stream produced by repeated shift operations back into bytes. Direction is latched from an ALU opcode, so bits from left shifts are packed MSB-first and bits from right shifts are packed LSB-first. A completed byte is held behind a valid/ready handshake until the consumer takes it. The block also provides a flush path that emits a zero-padded, aligned partial byte.

## Interface
- WIDTH, 8, assembled word width; the bit counter is `$clog2(WIDTH)+1` bits wide.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that latches `alu_op` and begins a collection.
- alu_op  input  4  opcode sampled on `start`. Only `SHLOP` and `SHROP` are legal.
- bit_valid  input  1  `bit_in` is valid this cycle.
- bit_in  input  1  serial data bit, normally the ALU `shift_overflow` output.
- bit_ready  output  1  the block accepts a bit this cycle.
- flush  input  1  emits the current partial byte, then returns to IDLE.
- byte_valid  output  1  `byte_out` holds a word.
- byte_ready  input  1  the consumer takes `byte_out`.
- byte_out  output  WIDTH  assembled word.
- byte_bits  output  $clog2(WIDTH)+1  number of real (non-pad) bits in `byte_out`, from 1 to WIDTH.
- op_error  output  1  one-cycle pulse when `start` carries an illegal opcode.

## Operation
- States:
  - IDLE: `bit_ready`=0.
  - COLLECT: `bit_ready`=1.
  - HOLD: `bit_ready`=0, `byte_valid`=1.
- A bit is accepted when `bit_valid & bit_ready`.
- Packing while the latched direction is SHL: `acc <= {acc[WIDTH-2:0], bit_in}`.
- Packing while the latched direction is SHR: `acc <= {bit_in, acc[WIDTH-1:1]}`.
- IDLE, `start` with `SHLOP`/`SHROP`: latch direction, clear `acc` and `count`, go to COLLECT.
- IDLE, `start` with any other opcode: pulse `op_error`, stay in IDLE.
- COLLECT, accepted bit: `count`+1. On the WIDTH-th bit, load `byte_out` with the final packed value, set `byte_bits`=WIDTH, go to HOLD with the stream flag set.
- COLLECT, `start`: restart. Re-latch direction, clear `acc` and `count`, stay in COLLECT. An illegal opcode pulses `op_error` and goes to IDLE. `start` wins over a simultaneous bit.
- COLLECT, `flush` with `count`=0: go to IDLE, no output.
- COLLECT, `flush` with `count`=k>0: align the partial word, set `byte_bits`=k, go to HOLD with the stream flag cleared.
  - SHL: `acc << (WIDTH-k)`, so the first bit lands in the MSB and the low bits are zero.
  - SHR: `acc >> (WIDTH-k)`, so the first bit lands in the LSB and the high bits are zero.
  - A bit presented in the same cycle as `flush` is accepted and included, and k counts it.
- HOLD, `byte_valid & byte_ready`:
  - Stream flag set: go to COLLECT with `acc` and `count` cleared and direction kept. This is continuous streaming.
  - Stream flag cleared: go to IDLE.
- HOLD: `start`, `flush` and `bit_valid` are ignored. `byte_out` and `byte_bits` stay stable until taken.
- Reset: state IDLE, `acc`=0, `count`=0, direction=SHL. Outputs: `byte_out`=0, `byte_bits`=0, `byte_valid`=0, `bit_ready`=0, `op_error`=0.
- Reset asserted mid-collection or in HOLD discards all data immediately.

## Timing
- `byte_valid` rises on the edge that accepts the WIDTH-th bit, and is visible the next cycle.
- `bit_ready` is registered and follows the state only.
- A full word needs 1 cycle of `start` plus WIDTH accepted bits.
- Minimum byte-to-byte spacing is WIDTH+1 cycles when `byte_ready` is held high: HOLD lasts 1 cycle.
- `op_error` is registered and high for exactly one cycle.
- No combinational path from any input to any output.

## Structure
- The opcode constants `SHLOP`/`SHROP` come from the shared `cpu_definitions.vh` header.
- Add to the same header:
  - the state encodings `SD_IDLE`, `SD_COLLECT`, `SD_HOLD`;
  - a direction constant `SD_DIR_SHL`/`SD_DIR_SHR`.
- One sub-module is natural: `shift_deserializer_align`. It is a combinational barrel aligner taking (`acc`, `count`, `dir`) and producing the aligned word for the flush path.
- Everything else is a single FSM plus datapath in `shift_deserializer`.

## Test plan
- SHL stream: `start` with `SHLOP`, then bits 1,0,1,1,0,0,1,0 -> `byte_out`=8'hB2, `byte_bits`=8, `byte_valid` the cycle after the 8th bit.
- SHR stream: `start` with `SHROP`, same bit sequence -> `byte_out`=8'h4D.
- Flush partial: SHL, bits 1,1,0 then `flush` -> `byte_out`=8'hC0, `byte_bits`=3; after the handshake the state is IDLE. The same case in SHR -> `byte_out`=8'h03.
- Backpressure/stream: `byte_ready`=0 for 5 cycles in HOLD while bits are driven -> `bit_ready`=0, `byte_out` stable, no bits lost. After the handshake, a second SHL byte 8'h5A is assembled with no further `start`.
- Illegal op: `start` with `PUROP` in IDLE -> `op_error` high for 1 cycle, state stays IDLE. `start` with `UNCOP` during COLLECT -> `op_error` pulse and a return to IDLE.
- Reset mid-op: assert `rst_n`=0 after 4 bits -> all outputs 0 asynchronously. After release, a fresh `start` yields a correct full byte.
